friscv_isa_regfile: RTL and testbench

// - Integer ISA register file (x0..x31, or x0..x15 when RV32E) serving the processing stage and the controller.
// - Provides combinational read ports: one rs1/rs2 pair for the controller, one per processing unit (ALU, memfy, M-ext).
// - Merges per-unit byte-strobed writes into the array. Resolves same-cycle write collisions by fixed priority.
// - Flags collisions and illegal RV32E accesses.

---
 rtl/friscv_isa_regfile_pkg.sv | 11 +
 rtl/friscv_regfile_wrmerge.sv | 56 +++++
 rtl/friscv_isa_regfile.sv | 100 ++++++++++
 tb/tb_friscv_isa_regfile.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/friscv_isa_regfile_pkg.sv
// friscv_h: shared integer register file constants for the friscv ISA slice.
package friscv_h;

    localparam int REG_ADDR_W = 5;
    localparam int NB_INT_REG = 32;

    function automatic int nb_live_reg(input int rv32e);
        return (rv32e != 0) ? 16 : NB_INT_REG;
    endfunction

endpackage

// File: rtl/friscv_regfile_wrmerge.sv
// friscv_regfile_wrmerge: per-register byte-enable and data merge of the controller and unit write ports.
// The controller always wins a byte; among units the lowest index wins.
module friscv_regfile_wrmerge
    import friscv_h::*;
#(
    parameter int XLEN    = 32,
    parameter int RV32E   = 0,
    parameter int NB_UNIT = 2
)(
    input  logic                          i_ctrl_wr,
    input  logic [REG_ADDR_W-1:0]         i_ctrl_addr,
    input  logic [XLEN-1:0]               i_ctrl_val,
    input  logic [NB_UNIT-1:0]            i_proc_wr,
    input  logic [NB_UNIT*REG_ADDR_W-1:0] i_proc_addr,
    input  logic [NB_UNIT*XLEN-1:0]       i_proc_val,
    input  logic [NB_UNIT*XLEN/8-1:0]     i_proc_strb,
    output logic [NB_INT_REG*XLEN/8-1:0]  o_wen,
    output logic [NB_INT_REG*XLEN-1:0]    o_wdata,
    output logic                          o_collision
);

    localparam int NB     = XLEN / 8;
    localparam int NB_REG = nb_live_reg(RV32E);

    logic w_seen;

    // Ports are visited lowest priority first so the winner is written last.
    // x0 and, in RV32E, x16..x31 never match, which drops those writes.
    always_comb begin
        o_wen       = '0;
        o_wdata     = '0;
        o_collision = 1'b0;
        w_seen      = 1'b0;
        for (int r = 1; r < NB_REG; r++) begin
            for (int b = 0; b < NB; b++) begin
                w_seen = 1'b0;
                for (int u = NB_UNIT - 1; u >= 0; u--) begin
                    if (i_proc_wr[u] && i_proc_strb[u*NB+b] &&
                        i_proc_addr[u*REG_ADDR_W+:REG_ADDR_W] == REG_ADDR_W'(r)) begin
                        o_collision             = o_collision | w_seen;
                        w_seen                  = 1'b1;
                        o_wen[r*NB+b]           = 1'b1;
                        o_wdata[r*XLEN+b*8+:8]  = i_proc_val[u*XLEN+b*8+:8];
                    end
                end
                if (i_ctrl_wr && i_ctrl_addr == REG_ADDR_W'(r)) begin
                    o_collision             = o_collision | w_seen;
                    w_seen                  = 1'b1;
                    o_wen[r*NB+b]           = 1'b1;
                    o_wdata[r*XLEN+b*8+:8]  = i_ctrl_val[b*8+:8];
                end
            end
        end
    end

endmodule

// File: rtl/friscv_isa_regfile.sv
// friscv_isa_regfile: integer ISA register file with controller and per-unit ports.
// Reads are combinational without write bypass; merged writes land on the rising edge.
module friscv_isa_regfile
    import friscv_h::*;
#(
    parameter int XLEN    = 32,
    parameter int RV32E   = 0,
    parameter int NB_UNIT = 2
)(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          srst,
    input  logic [REG_ADDR_W-1:0]         i_ctrl_rs1_addr,
    output logic [XLEN-1:0]               o_ctrl_rs1_val,
    input  logic [REG_ADDR_W-1:0]         i_ctrl_rs2_addr,
    output logic [XLEN-1:0]               o_ctrl_rs2_val,
    input  logic                          i_ctrl_rd_wr,
    input  logic [REG_ADDR_W-1:0]         i_ctrl_rd_addr,
    input  logic [XLEN-1:0]               i_ctrl_rd_val,
    input  logic [NB_UNIT*REG_ADDR_W-1:0] i_proc_rs1_addr,
    output logic [NB_UNIT*XLEN-1:0]       o_proc_rs1_val,
    input  logic [NB_UNIT*REG_ADDR_W-1:0] i_proc_rs2_addr,
    output logic [NB_UNIT*XLEN-1:0]       o_proc_rs2_val,
    input  logic [NB_UNIT-1:0]            i_proc_rd_wr,
    input  logic [NB_UNIT*REG_ADDR_W-1:0] i_proc_rd_addr,
    input  logic [NB_UNIT*XLEN-1:0]       i_proc_rd_val,
    input  logic [NB_UNIT*XLEN/8-1:0]     i_proc_rd_strb,
    output logic                          o_wr_collision,
    output logic                          o_rv32e_err
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0]              r_regs [NB_INT_REG];
    logic                         r_wr_collision;
    logic                         r_rv32e_err;
    logic [NB_INT_REG*NB-1:0]     w_wen;
    logic [NB_INT_REG*XLEN-1:0]   w_wdata;
    logic                         w_collision;
    logic                         w_e_hit;

    friscv_regfile_wrmerge #(
        .XLEN    (XLEN),
        .RV32E   (RV32E),
        .NB_UNIT (NB_UNIT)
    ) u_wrmerge (
        .i_ctrl_wr   (i_ctrl_rd_wr),
        .i_ctrl_addr (i_ctrl_rd_addr),
        .i_ctrl_val  (i_ctrl_rd_val),
        .i_proc_wr   (i_proc_rd_wr),
        .i_proc_addr (i_proc_rd_addr),
        .i_proc_val  (i_proc_rd_val),
        .i_proc_strb (i_proc_rd_strb),
        .o_wen       (w_wen),
        .o_wdata     (w_wdata),
        .o_collision (w_collision)
    );

    function automatic logic [XLEN-1:0] rd(input logic [REG_ADDR_W-1:0] a);
        return (a == '0 || (RV32E != 0 && a[4])) ? '0 : r_regs[a];
    endfunction

    assign o_ctrl_rs1_val = rd(i_ctrl_rs1_addr);
    assign o_ctrl_rs2_val = rd(i_ctrl_rs2_addr);

    for (genvar i = 0; i < NB_UNIT; i++) begin : g_rd
        assign o_proc_rs1_val[i*XLEN+:XLEN] = rd(i_proc_rs1_addr[i*REG_ADDR_W+:REG_ADDR_W]);
        assign o_proc_rs2_val[i*XLEN+:XLEN] = rd(i_proc_rs2_addr[i*REG_ADDR_W+:REG_ADDR_W]);
    end

    // Any touch of x16..x31, read or enabled write, is an RV32E violation.
    always_comb begin
        w_e_hit = i_ctrl_rs1_addr[4] | i_ctrl_rs2_addr[4] | (i_ctrl_rd_wr & i_ctrl_rd_addr[4]);
        for (int u = 0; u < NB_UNIT; u++)
            w_e_hit = w_e_hit | i_proc_rs1_addr[u*REG_ADDR_W+4] | i_proc_rs2_addr[u*REG_ADDR_W+4]
                    | (i_proc_rd_wr[u] & i_proc_rd_addr[u*REG_ADDR_W+4]);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < NB_INT_REG; r++) r_regs[r] <= '0;
            r_wr_collision <= 1'b0;
            r_rv32e_err    <= 1'b0;
        end else if (srst) begin
            for (int r = 0; r < NB_INT_REG; r++) r_regs[r] <= '0;
            r_wr_collision <= 1'b0;
            r_rv32e_err    <= 1'b0;
        end else begin
            for (int r = 0; r < NB_INT_REG; r++)
                for (int b = 0; b < NB; b++)
                    if (w_wen[r*NB+b]) r_regs[r][b*8+:8] <= w_wdata[r*XLEN+b*8+:8];
            r_wr_collision <= w_collision;
            r_rv32e_err    <= (RV32E != 0) && w_e_hit;
        end
    end

    assign o_wr_collision = r_wr_collision;
    assign o_rv32e_err    = r_rv32e_err;

endmodule

// File: tb/tb_friscv_isa_regfile.sv
// tb_friscv_isa_regfile: vector table plus scoreboard queue checking a full-size and an RV32E register file.
module tb_friscv_isa_regfile;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        srst = 1'b0;
    logic [4:0]  c_rs1, c_rs2;
    logic [9:0]  p_rs1, p_rs2;
    logic        c_wr;
    logic [4:0]  c_addr;
    logic [31:0] c_val;
    logic [1:0]  p_wr;
    logic [9:0]  p_addr;
    logic [63:0] p_val;
    logic [7:0]  p_strb;
    logic [31:0] c1, c2, c1_e, c2_e;
    logic [63:0] p1, p2, p1_e, p2_e;
    logic        coll, err, coll_e, err_e;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    friscv_isa_regfile #(.XLEN(32), .RV32E(0), .NB_UNIT(2)) dut (
        .aclk(clk), .aresetn(aresetn), .srst(srst),
        .i_ctrl_rs1_addr(c_rs1), .o_ctrl_rs1_val(c1),
        .i_ctrl_rs2_addr(c_rs2), .o_ctrl_rs2_val(c2),
        .i_ctrl_rd_wr(c_wr), .i_ctrl_rd_addr(c_addr), .i_ctrl_rd_val(c_val),
        .i_proc_rs1_addr(p_rs1), .o_proc_rs1_val(p1),
        .i_proc_rs2_addr(p_rs2), .o_proc_rs2_val(p2),
        .i_proc_rd_wr(p_wr), .i_proc_rd_addr(p_addr), .i_proc_rd_val(p_val),
        .i_proc_rd_strb(p_strb), .o_wr_collision(coll), .o_rv32e_err(err)
    );

    friscv_isa_regfile #(.XLEN(32), .RV32E(1), .NB_UNIT(2)) dut_e (
        .aclk(clk), .aresetn(aresetn), .srst(srst),
        .i_ctrl_rs1_addr(c_rs1), .o_ctrl_rs1_val(c1_e),
        .i_ctrl_rs2_addr(c_rs2), .o_ctrl_rs2_val(c2_e),
        .i_ctrl_rd_wr(c_wr), .i_ctrl_rd_addr(c_addr), .i_ctrl_rd_val(c_val),
        .i_proc_rs1_addr(p_rs1), .o_proc_rs1_val(p1_e),
        .i_proc_rs2_addr(p_rs2), .o_proc_rs2_val(p2_e),
        .i_proc_rd_wr(p_wr), .i_proc_rd_addr(p_addr), .i_proc_rd_val(p_val),
        .i_proc_rd_strb(p_strb), .o_wr_collision(coll_e), .o_rv32e_err(err_e)
    );

    typedef struct {
        logic        cw;
        logic [4:0]  ca;
        logic [31:0] cv;
        logic [1:0]  uw;
        logic [4:0]  ua0;
        logic [31:0] uv0;
        logic [3:0]  us0;
        logic [4:0]  ua1;
        logic [31:0] uv1;
        logic [3:0]  us1;
        logic [4:0]  chk;
        logic [31:0] exp;
        logic        ecoll;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [4:0]  chk;
        logic [31:0] exp;
        logic        ecoll;
        logic        eerr;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic set_reads(input logic [4:0] a);
        c_rs1 = a; c_rs2 = a; p_rs1 = {a, a}; p_rs2 = {a, a};
    endtask

    task automatic check_reads(input string nm, input logic [31:0] req);
        chk({nm, " ctrl_rs1"}, c1, req);
        chk({nm, " ctrl_rs2"}, c2, req);
        chk({nm, " u0_rs1"}, p1[31:0], req);
        chk({nm, " u1_rs1"}, p1[63:32], req);
        chk({nm, " u0_rs2"}, p2[31:0], req);
        chk({nm, " u1_rs2"}, p2[63:32], req);
    endtask

    task automatic idle_writes();
        c_wr = 1'b0; c_addr = '0; c_val = '0;
        p_wr = '0; p_addr = '0; p_val = '0; p_strb = '0;
    endtask

    task automatic drive(input vec_t v);
        c_wr = v.cw; c_addr = v.ca; c_val = v.cv;
        p_wr = v.uw; p_addr = {v.ua1, v.ua0}; p_val = {v.uv1, v.uv0};
        p_strb = {v.us1, v.us0};
        set_reads(v.chk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [4:0] rs [5];
        vecs[0] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 32'h11111111, 4'h3, 5'd7, 32'h22222222, 4'h6, 5'd7, 32'h00221111, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd3, 32'hAAAAAAAA, 2'b10, 5'd0, 32'h0, 4'h0, 5'd3, 32'h55555555, 4'hF, 5'd3, 32'hAAAAAAAA, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 32'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 32'h0, 4'h0, 5'd9, 32'hCAFEF00D, 4'hF, 5'd9, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 32'h000000AB, 4'h1, 5'd9, 32'h0000CD00, 4'h2, 5'd9, 32'hCAFECDAB, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd10, 32'h12345678, 4'h0, 5'd0, 32'h0, 4'h0, 5'd10, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 5'd11, 32'h01020304, 2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, 5'd11, 32'h01020304, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd12, 32'h00000011, 4'hF, 5'd12, 32'h00000022, 4'hF, 5'd12, 32'h00000011, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd20, 32'h00001234, 4'hF, 5'd0, 32'h0, 4'h0, 5'd20, 32'h00001234, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 5'd3, 32'h0BADF00D, 2'b01, 5'd3, 32'hFFFFFFFF, 4'h8, 5'd0, 32'h0, 4'h0, 5'd3, 32'h0BADF00D, 1'b1, 1'b0};
        idle_writes();
        set_reads(5'd0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("reset coll", {31'b0, coll}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        chk("reset coll_e", {31'b0, coll_e}, 32'd0);
        chk("reset err_e", {31'b0, err_e}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_reads(5'(a));
            #1;
            check_reads($sformatf("reset x%0d", a), 32'h0);
        end
        // x5 write: invisible in the same cycle, visible on every port next cycle
        @(negedge clk);
        p_wr = 2'b01; p_addr = {5'd0, 5'd5}; p_val = {32'h0, 32'hDEADBEEF}; p_strb = 8'h0F;
        set_reads(5'd5);
        #1;
        check_reads("x5 same cycle", 32'h0);
        @(negedge clk);
        idle_writes();
        check_reads("x5 next cycle", 32'hDEADBEEF);
        chk("x5 coll", {31'b0, coll}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("v%0d coll cleared", i), {31'b0, coll}, 32'd0);
            drive(vecs[i]);
            sb.push_back('{vecs[i].chk, vecs[i].exp, vecs[i].ecoll, vecs[i].eerr});
            @(negedge clk);
            idle_writes();
            e = sb.pop_front();
            check_reads($sformatf("v%0d x%0d", i, e.chk), e.exp);
            chk($sformatf("v%0d coll", i), {31'b0, coll}, {31'b0, e.ecoll});
            chk($sformatf("v%0d err", i), {31'b0, err}, 32'd0);
            chk($sformatf("v%0d e_val", i), c1_e, e.chk[4] ? 32'h0 : e.exp);
            chk($sformatf("v%0d err_e", i), {31'b0, err_e}, {31'b0, e.eerr});
        end
        // srst together with a colliding write: state and flag both clear
        @(negedge clk);
        srst = 1'b1;
        p_wr = 2'b11; p_addr = {5'd15, 5'd15}; p_val = {32'h77777777, 32'h66666666}; p_strb = 8'hFF;
        @(negedge clk);
        srst = 1'b0;
        idle_writes();
        chk("srst coll", {31'b0, coll}, 32'd0);
        rs = '{5'd3, 5'd5, 5'd9, 5'd11, 5'd15};
        for (int k = 0; k < 5; k++) begin
            set_reads(rs[k]);
            #1;
            check_reads($sformatf("srst x%0d", rs[k]), 32'h0);
        end
        // asynchronous reset clears without a clock edge
        @(negedge clk);
        p_wr = 2'b01; p_addr = {5'd0, 5'd13}; p_val = {32'h0, 32'h5A5A5A5A}; p_strb = 8'h0F;
        set_reads(5'd13);
        @(negedge clk);
        idle_writes();
        #1;
        chk("async pre x13", c1, 32'h5A5A5A5A);
        #1 aresetn = 1'b0;
        #1;
        chk("async x13", c1, 32'h0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
